// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master round-robin arbiter in front of the shared unified memory
//   (program/data plus LED/RGB MMIO). Master 0 is the multicycle core and
//   master 1 is the secondary requester (boot loader / debug / DMA). The
//   arbiter runs one transaction at a time. It also absorbs the memory's
//   one-cycle synchronous read latency, so masters only see a req/ack
//   handshake.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   m0_req / m1_req     request, held high until the matching ack
//   m0_we  / m1_we      1 = write, 0 = read; stable while req is high
//   m0_adr / m1_adr     byte address; stable while req is high
//   m0_wdata/m1_wdata   write data; stable while req is high
//   m0_ack / m1_ack     one-cycle completion pulse
//   m0_rdata/m1_rdata   read data; valid only in the ack cycle of a read
//   mem_we              memory write enable
//   mem_adr             memory address
//   mem_wdata           memory write data
//   mem_rdata           memory read data, one cycle after mem_adr
//   gnt                 index of the master that owns the bus (valid while busy)
//   busy                high in ACCESS and DATA
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | bus free; requests are sampled and a winner is picked
// ACCESS | address phase; a write commits and is acked on this cycle
// DATA   | read data returns from memory; the read is acked this cycle

module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t state;
  logic   last;
  logic   pick;

  // On a tie the master that did not win last time gets the bus.
  // With a single requester, that requester wins.
  assign pick = (m0_req && m1_req) ? ~last : m1_req;

  // The memory output is shared by both masters. Each master may only use
  // it in the cycle where its ack is high.
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      gnt       <= 1'b0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state     <= ACCESS;
            gnt       <= pick;
            busy      <= 1'b1;
            // The winner's request is captured here. Dropping req after
            // the grant therefore cannot disturb the transfer.
            mem_adr   <= pick ? m1_adr   : m0_adr;
            mem_wdata <= pick ? m1_wdata : m0_wdata;
            mem_we    <= pick ? m1_we    : m0_we;
            // A write is acked during ACCESS, i.e. the cycle whose closing
            // edge commits it to memory.
            m0_ack    <= ~pick & m0_we;
            m1_ack    <= pick & m1_we;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (mem_we) begin
            state   <= IDLE;
            busy    <= 1'b0;
            last    <= gnt;
            mem_adr <= '0;
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
          end else begin
            state   <= DATA;
            m0_ack  <= ~gnt;
            m1_ack  <= gnt;
          end
        end
        DATA: begin
          state   <= IDLE;
          busy    <= 1'b0;
          last    <= gnt;
          mem_adr <= '0;
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_we  <= 1'b0;
          mem_adr <= '0;
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam logic [31:0] LED_ADR = 32'h8000_0000;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_ack;
  logic [31:0] m0_adr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack;
  logic [31:0] m1_adr, m1_wdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        gnt, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the unified memory: synchronous read, write on the rising edge,
  // with one LED register mapped at LED_ADR.
  logic [31:0] mem_arr [0:255];
  logic [31:0] led;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gnt(gnt), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_adr == LED_ADR) led <= mem_wdata;
      else mem_arr[mem_adr[9:2]] <= mem_wdata;
    end
    mem_rdata <= (mem_adr == LED_ADR) ? led : mem_arr[mem_adr[9:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_adr = 32'h100; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_we = 1'b1; m1_adr = 32'h104; m1_wdata = 32'h2;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt got %b want 0", gnt); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_adr !== 32'h0) begin n_err++; $display("FAIL reset_mem_adr got %h want 0", mem_adr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks got %b want 00", {m0_ack, m1_ack}); end
    m0_req = 1'b0; m1_req = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_adr = 32'h100; m0_wdata = 32'hDEAD_BEEF;
    tick();  // IDLE -> ACCESS, write acked in this cycle
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL wr_mem_we got %b want 1", mem_we); end
    n_cmp++; if (mem_adr !== 32'h100) begin n_err++; $display("FAIL wr_mem_adr got %h want 100", mem_adr); end
    n_cmp++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_mem_wdata got %h want deadbeef", mem_wdata); end
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b10) begin n_err++; $display("FAIL wr_ack got %b want 10", {m0_ack, m1_ack}); end
    n_cmp++; if ({busy, gnt} !== 2'b10) begin n_err++; $display("FAIL wr_busy_gnt got %b want 10", {busy, gnt}); end
    m0_req = 1'b0;
    tick();  // commit edge, back to IDLE
    n_cmp++; if ({m0_ack, busy, mem_we} !== 3'b000) begin n_err++; $display("FAIL wr_done got %b want 000", {m0_ack, busy, mem_we}); end
    n_cmp++; if (mem_arr[64] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_commit got %h want deadbeef", mem_arr[64]); end
    m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h100;
    tick();  // ACCESS for the read: no ack yet
    n_cmp++; if ({m0_ack, mem_we} !== 2'b00) begin n_err++; $display("FAIL rd_access got %b want 00", {m0_ack, mem_we}); end
    n_cmp++; if (mem_adr !== 32'h100) begin n_err++; $display("FAIL rd_mem_adr got %h want 100", mem_adr); end
    tick();  // DATA: ack with read data
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b10) begin n_err++; $display("FAIL rd_ack got %b want 10", {m0_ack, m1_ack}); end
    n_cmp++; if (m0_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data got %h want deadbeef", m0_rdata); end
    m0_req = 1'b0;
    tick();
    n_cmp++; if ({m0_ack, busy} !== 2'b00) begin n_err++; $display("FAIL rd_done got %b want 00", {m0_ack, busy}); end
  endtask

  task automatic test_round_robin();
    int acks = 0;
    int cyc = 0;
    pulse_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h104;
    while (acks < 6 && cyc < 40) begin
      tick();
      cyc++;
      n_cmp++; if (m0_ack && m1_ack) begin n_err++; $display("FAIL rr_double_ack got 11 want at most one"); end
      if (m0_ack || m1_ack) begin
        n_cmp++; if (m1_ack !== acks[0]) begin n_err++; $display("FAIL rr_order ack %0d got m%0d want m%0d", acks, m1_ack, acks[0]); end
        n_cmp++; if (gnt !== acks[0]) begin n_err++; $display("FAIL rr_gnt ack %0d got %b want %b", acks, gnt, acks[0]); end
        acks++;
      end
    end
    n_cmp++; if (acks != 6) begin n_err++; $display("FAIL rr_timeout got %0d acks want 6", acks); end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_mmio_contention();
    int cyc = 0;
    int t0 = -1;
    int t1 = -1;
    pulse_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b1; m1_adr = LED_ADR; m1_wdata = 32'h0000_00A5;
    while ((t0 < 0 || t1 < 0) && cyc < 20) begin
      tick();
      cyc++;
      if (m0_ack) begin
        t0 = cyc;
        n_cmp++; if (m0_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mmio_m0_rdata got %h want deadbeef", m0_rdata); end
        m0_req = 1'b0;
      end
      if (m1_ack) begin
        t1 = cyc;
        n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL mmio_m1_we got %b want 1", mem_we); end
        m1_req = 1'b0;
      end
    end
    n_cmp++; if (t0 != 2) begin n_err++; $display("FAIL mmio_m0_latency got %0d want 2", t0); end
    // Read ack, one IDLE cycle, then the write is acked in ACCESS.
    n_cmp++; if (t1 - t0 != 2) begin n_err++; $display("FAIL mmio_gap got %0d want 2", t1 - t0); end
    tick();
    n_cmp++; if (led !== 32'h0000_00A5) begin n_err++; $display("FAIL mmio_led got %h want a5", led); end
  endtask

  task automatic test_reset_mid_write();
    m0_req = 1'b1; m0_we = 1'b1; m0_adr = 32'h100; m0_wdata = 32'h1234_5678;
    tick();  // in ACCESS, write pending
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if ({mem_we, m0_ack, busy} !== 3'b000) begin n_err++; $display("FAIL rst_mid got %b want 000", {mem_we, m0_ack, busy}); end
    n_cmp++; if (mem_adr !== 32'h0) begin n_err++; $display("FAIL rst_mid_adr got %h want 0", mem_adr); end
    tick();
    n_cmp++; if (mem_arr[64] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rst_dropped got %h want deadbeef", mem_arr[64]); end
    reset = 1'b1;
    tick();  // pending request served again
    n_cmp++; if ({m0_ack, mem_we} !== 2'b11) begin n_err++; $display("FAIL rst_retry got %b want 11", {m0_ack, mem_we}); end
    m0_req = 1'b0;
    tick();
    n_cmp++; if (mem_arr[64] !== 32'h1234_5678) begin n_err++; $display("FAIL rst_retry_commit got %h want 12345678", mem_arr[64]); end
  endtask

  task automatic test_drop_req();
    int m0_acks = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h100;
    tick();  // ACCESS for m0
    n_cmp++; if ({busy, gnt} !== 2'b10) begin n_err++; $display("FAIL drop_grant got %b want 10", {busy, gnt}); end
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_adr = LED_ADR;
    tick();  // DATA for m0
    if (m0_ack) m0_acks++;
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b10) begin n_err++; $display("FAIL drop_ack got %b want 10", {m0_ack, m1_ack}); end
    n_cmp++; if (m0_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL drop_rdata got %h want 12345678", m0_rdata); end
    tick();  // IDLE
    if (m0_ack) m0_acks++;
    tick();  // ACCESS for m1
    if (m0_ack) m0_acks++;
    n_cmp++; if ({busy, gnt, m1_ack} !== 3'b110) begin n_err++; $display("FAIL drop_m1_grant got %b want 110", {busy, gnt, m1_ack}); end
    tick();  // DATA for m1
    if (m0_ack) m0_acks++;
    n_cmp++; if (m1_ack !== 1'b1) begin n_err++; $display("FAIL drop_m1_ack got %b want 1", m1_ack); end
    n_cmp++; if (m1_rdata !== 32'h0000_00A5) begin n_err++; $display("FAIL drop_m1_rdata got %h want a5", m1_rdata); end
    m1_req = 1'b0;
    tick();
    n_cmp++; if (m0_acks != 1) begin n_err++; $display("FAIL drop_m0_ack_count got %0d want 1", m0_acks); end
  endtask

  initial begin
    reset = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_mmio_contention();
    test_reset_mid_write();
    test_drop_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
